// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor controller.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_sub_bit.sv
// Combinational 1-bit full subtractor: y = a - b - bin, bout is the borrow out.
module full_sub_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_y,
  output logic o_bout
);

  assign o_y    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: diff = a - b - borrow_in, LSB first, one bit per enabled clock.
// Optional SERIAL_SUB_OVF_EN adds o_ovf, the signed overflow flag of the same operation.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_borrow_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             o_ovf,
`endif
  output logic             o_borrow_out
);

  localparam int CNT_W = clog2(WIDTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_diff;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_brw;
  logic               r_borrow_out;
  logic               w_y;
  logic               w_bo;
  logic               w_last;
  logic               w_accept;

  full_sub_bit u_stage (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_bin  (r_brw),
    .o_y    (w_y),
    .o_bout (w_bo)
  );

  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept = (r_state == IDLE) && i_start;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // DONE always falls back to IDLE on the next edge, enabled or not.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_en && i_start) w_state_nxt = RUN;
      RUN:     if (i_en && w_last)  w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_diff       <= '0;
      r_cnt        <= '0;
      r_brw        <= 1'b0;
      r_borrow_out <= 1'b0;
    end else if (i_en) begin
      if (w_accept) begin
        r_a_sh <= i_a;
        r_b_sh <= i_b;
        r_brw  <= i_borrow_in;
        r_cnt  <= '0;
      end else if (r_state == RUN) begin
        r_a_sh <= r_a_sh >> 1;
        r_b_sh <= r_b_sh >> 1;
        r_diff <= {w_y, r_diff[WIDTH-1:1]};
        r_brw  <= w_bo;
        r_cnt  <= r_cnt + CNT_W'(1);
        if (w_last) r_borrow_out <= w_bo;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // Borrow into the MSB stage differs from borrow out of it exactly on signed overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst)                              r_ovf <= 1'b0;
    else if (i_en && r_state == RUN && w_last) r_ovf <= r_brw ^ w_bo;
  end

  assign o_ovf = r_ovf;
`endif

  assign o_busy       = (r_state != IDLE);
  assign o_done       = (r_state == DONE);
  assign o_diff       = r_diff;
  assign o_borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed cases plus randomized traffic against an arithmetic model.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         start = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_diff;
  logic         o_borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         o_ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_start      (start),
    .i_a          (a),
    .i_b          (b),
    .i_borrow_in  (bin),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_diff       (o_diff),
`ifdef SERIAL_SUB_OVF_EN
    .o_ovf        (o_ovf),
`endif
    .o_borrow_out (o_borrow_out)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 running, 2 done; result from plain arithmetic.
  int           m_phase = 0;
  int           m_steps = 0;
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_old = '0;
  logic [W-1:0] m_diff = '0;
  logic         m_bor = 1'b0;
  logic         m_bo = 1'b0;
  logic         m_ovf_calc = 1'b0;
  logic         m_ovf = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_steps = 0;
      m_diff  = '0;
      m_bo    = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      case (m_phase)
        0: if (en && start) begin
          logic [W:0] full;
          int sa, sb, r;
          full  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
          m_res = full[W-1:0];
          m_bor = full[W];
          sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
          sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
          r  = sa - sb - int'(bin);
          m_ovf_calc = (r < -(1 << (W-1))) || (r > (1 << (W-1)) - 1);
          m_old   = m_diff;
          m_steps = 0;
          m_phase = 1;
        end
        1: if (en) begin
          m_steps++;
          m_diff = (m_res << (W - m_steps)) | (m_old >> m_steps);
          if (m_steps == W) begin
            m_bo    = m_bor;
            m_ovf   = m_ovf_calc;
            m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, o_busy}, {31'd0, m_phase != 0});
      check("done", {31'd0, o_done}, {31'd0, m_phase == 2});
      check("diff", {24'd0, o_diff}, {24'd0, m_diff});
      check("borrow_out", {31'd0, o_borrow_out}, {31'd0, m_bo});
`ifdef SERIAL_SUB_OVF_EN
      check("ovf", {31'd0, o_ovf}, {31'd0, m_ovf});
`endif
    end
  end

  // Issues one operation; lat is edges from the start edge until done is visible.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        input int pause_at, input int pause_len, input int restart_at,
                        output int lat, output logic [W-1:0] d, output logic bo, output logic ov);
    int cyc;
    a = ta; b = tb_v; bin = tbin; start = 1'b1; en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("busy_after_start", {31'd0, o_busy}, 32'd1);
    while (!o_done && cyc < 200) begin
      if (cyc == pause_at) en = 1'b0;
      if (cyc == pause_at + pause_len) en = 1'b1;
      if (cyc == restart_at) begin start = 1'b1; a = '1; b = '1; bin = 1'b1; end
      if (cyc == restart_at + 1) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (!o_done) check("done_timeout", 32'd0, 32'd1);
    en  = 1'b1;
    lat = cyc - 1;
    d   = o_diff;
    bo  = o_borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    ov  = o_ovf;
`else
    ov  = 1'b0;
`endif
    @(negedge clk);
    check("done_single_pulse", {31'd0, o_done}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [W-1:0] d;
    logic bo, ov;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_diff", {24'd0, o_diff}, 32'd0);
    check("rst_borrow_out", {31'd0, o_borrow_out}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Basic subtraction and latency.
    run_op(8'h05, 8'h03, 1'b0, -1, 0, -1, lat, d, bo, ov);
    check("c1_latency", lat, 32'd8);
    check("c1_diff", {24'd0, d}, 32'h02);
    check("c1_borrow", {31'd0, bo}, 32'd0);
    check("c1_model_diff", {24'd0, m_diff}, 32'h02);

    // Underflow with borrow_in, result held while idle.
    run_op(8'h00, 8'h01, 1'b1, -1, 0, -1, lat, d, bo, ov);
    check("c2_diff", {24'd0, d}, 32'hFE);
    check("c2_borrow", {31'd0, bo}, 32'd1);
    check("c2_model_borrow", {31'd0, m_bo}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("c2_hold_diff", {24'd0, o_diff}, 32'hFE);
      check("c2_hold_borrow", {31'd0, o_borrow_out}, 32'd1);
    end

    // Enable dropped for three cycles mid-run.
    run_op(8'h05, 8'h03, 1'b0, 3, 3, -1, lat, d, bo, ov);
    check("c3_latency", lat, 32'd11);
    check("c3_diff", {24'd0, d}, 32'h02);

    // Start while busy is ignored.
    run_op(8'h10, 8'h01, 1'b0, -1, 0, 3, lat, d, bo, ov);
    check("c4_latency", lat, 32'd8);
    check("c4_diff", {24'd0, d}, 32'h0F);
    check("c4_borrow", {31'd0, bo}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("c4_no_extra_done", {31'd0, o_done}, 32'd0);
    end

    // Reset during RUN aborts the operation.
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1; en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("c5_busy", {31'd0, o_busy}, 32'd0);
    check("c5_done", {31'd0, o_done}, 32'd0);
    check("c5_diff", {24'd0, o_diff}, 32'd0);
    check("c5_borrow", {31'd0, o_borrow_out}, 32'd0);
    repeat (12) begin
      @(negedge clk);
      check("c5_no_done", {31'd0, o_done}, 32'd0);
    end
    run_op(8'h33, 8'h11, 1'b0, -1, 0, -1, lat, d, bo, ov);
    check("c5_restart_diff", {24'd0, d}, 32'h22);
    check("c5_restart_latency", lat, 32'd8);

`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, 1'b0, -1, 0, -1, lat, d, bo, ov);
    check("c6_diff", {24'd0, d}, 32'h7F);
    check("c6_borrow", {31'd0, bo}, 32'd0);
    check("c6_ovf", {31'd0, ov}, 32'd1);
    check("c6_model_ovf", {31'd0, m_ovf}, 32'd1);
    run_op(8'h05, 8'h03, 1'b0, -1, 0, -1, lat, d, bo, ov);
    check("c6b_ovf", {31'd0, ov}, 32'd0);
`endif

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 149) == 0);
      en    = ($urandom_range(0, 7) != 0);
      start = ($urandom_range(0, 2) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom_range(0, 1));
    end
    rst = 1'b0; start = 1'b0; en = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
